bpu_sched: RTL and testbench

Scheduler in front of the single-ported `bpu`. It arbitrates each cycle between fetch prediction requests and retired-branch training updates and buffers updates in an in-order queue. It tracks how many predictions are still awaiting training and sequences the flush window after a mispredicted branch. It sits between the fetch unit, the retire/resolve path, and `bpu`, and is the only driver of `bpu_req_i`, `bpu_update_i` and `bpu_flush_i`.

---
 rtl/bpu_sched.sv | 215 +++++++++++++++++++++
 tb/tb_bpu_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_sched.sv
// Arbitrates the single-ported bpu between fetch predictions and retired-branch updates.
// Updates are held in an in-order queue, and a mispredicted update opens a fetch-blocking flush window.
module bpu_sched #(
    parameter int PC         = 32,
    parameter int TAGE_IND   = 4,
    parameter int QDEPTH     = 8,
    parameter int STARVE_MAX = 4,
    parameter int MAX_INFL   = 15,
    parameter int FLUSH_CYC  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_req_i,
    input  logic [PC-1:0]                 fetch_addr_i,
    output logic                          fetch_gnt_o,
    input  logic                          ret_val_i,
    output logic                          ret_rdy_o,
    input  logic [PC-1:0]                 ret_pc_i,
    input  logic                          ret_taken_i,
    input  logic [TAGE_IND-1:0]           ret_tage_ind_i,
    input  logic                          ret_mispred_i,
    output logic                          bpu_req_o,
    output logic [PC-1:0]                 bpu_addr_o,
    output logic                          bpu_update_o,
    output logic [PC-1:0]                 bpu_pc_o,
    output logic                          bpu_taken_o,
    output logic [TAGE_IND-1:0]           bpu_tage_ind_o,
    output logic                          bpu_flush_o,
    output logic [$clog2(QDEPTH):0]       q_count_o,
    output logic [$clog2(MAX_INFL+1)-1:0] infl_o
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(MAX_INFL + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CW-1:0] Q_FULL     = CW'(QDEPTH);
    localparam logic [IW-1:0] INFL_FULL  = IW'(MAX_INFL);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [FW-1:0] FCNT_INIT  = FW'(FLUSH_CYC - 1);

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

    typedef struct packed {
        logic [PC-1:0]       pc;
        logic                taken;
        logic [TAGE_IND-1:0] tage_ind;
        logic                mispred;
    } entry_t;

    entry_t              mem_q [QDEPTH];
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [IW-1:0]       infl_q, infl_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    state_e              state_q, state_d;

    logic                bpu_req_q, bpu_update_q, bpu_taken_q, bpu_flush_q;
    logic [PC-1:0]       bpu_addr_q, bpu_pc_q;
    logic [TAGE_IND-1:0] bpu_tage_ind_q;

    entry_t              head_s;
    logic                enq_s, upd_elig_s, fetch_elig_s, upd_win_s, gnt_s, flush_s;

    // Arbitration between the queued update and the fetch request
    always_comb begin
        head_s       = mem_q[rptr_q];
        enq_s        = ret_val_i && (count_q != Q_FULL);
        upd_elig_s   = (count_q != {CW{1'b0}}) && (infl_q != {IW{1'b0}});
        // Gated by rst_n so no grant is visible while reset is held
        fetch_elig_s = rst_n && fetch_req_i && (state_q == ST_RUN) && (infl_q != INFL_FULL);
        upd_win_s    = upd_elig_s && (!fetch_elig_s || (count_q == Q_FULL) || (starve_q == STARVE_LIM));
        gnt_s        = fetch_elig_s && !upd_win_s;
        flush_s      = upd_win_s && head_s.mispred;
    end

    // Queue pointers, occupancy, starvation and in-flight bookkeeping
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        infl_d   = infl_q;
        starve_d = starve_q;
        if (enq_s) begin
            wptr_d = wptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (upd_win_s) begin
            rptr_d = rptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        case ({enq_s, upd_win_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        // A flush discards wrong-path predictions; only the entries still queued remain owed
        if (flush_s) begin
            infl_d = IW'(count_q - {{(CW-1){1'b0}}, 1'b1});
        end else if (gnt_s) begin
            infl_d = infl_q + {{(IW-1){1'b0}}, 1'b1};
        end else if (upd_win_s) begin
            infl_d = infl_q - {{(IW-1){1'b0}}, 1'b1};
        end else begin
            infl_d = infl_q;
        end
        if (upd_win_s || (count_q == {CW{1'b0}})) begin
            starve_d = {SW{1'b0}};
        end else if (gnt_s && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            starve_d = starve_q;
        end
    end

    // Flush window sequencing; a mispredict inside the window restarts it
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_s) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCNT_INIT;
                end else begin
                    state_d = ST_RUN;
                    fcnt_d  = fcnt_q;
                end
            end
            ST_FLUSH: begin
                if (flush_s) begin
                    fcnt_d = FCNT_INIT;
                end else if (fcnt_q == {FW{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - {{(FW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = {FW{1'b0}};
            end
        endcase
    end

    // Queue storage; reset only clears the pointers, stale data is never read
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_q[wptr_q] <= '{pc: ret_pc_i, taken: ret_taken_i,
                               tage_ind: ret_tage_ind_i, mispred: ret_mispred_i};
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= {PW{1'b0}};
            rptr_q   <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            infl_q   <= {IW{1'b0}};
            starve_q <= {SW{1'b0}};
            fcnt_q   <= {FW{1'b0}};
            state_q  <= ST_RUN;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            infl_q   <= infl_d;
            starve_q <= starve_d;
            fcnt_q   <= fcnt_d;
            state_q  <= state_d;
        end
    end

    // Registered bpu-side outputs, one cycle after the decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpu_req_q      <= 1'b0;
            bpu_addr_q     <= {PC{1'b0}};
            bpu_update_q   <= 1'b0;
            bpu_pc_q       <= {PC{1'b0}};
            bpu_taken_q    <= 1'b0;
            bpu_tage_ind_q <= {TAGE_IND{1'b0}};
            bpu_flush_q    <= 1'b0;
        end else begin
            bpu_req_q    <= gnt_s;
            bpu_update_q <= upd_win_s;
            bpu_flush_q  <= flush_s;
            if (gnt_s) begin
                bpu_addr_q <= fetch_addr_i;
            end
            if (upd_win_s) begin
                bpu_pc_q       <= head_s.pc;
                bpu_taken_q    <= head_s.taken;
                bpu_tage_ind_q <= head_s.tage_ind;
            end
        end
    end

    assign fetch_gnt_o    = gnt_s;
    assign ret_rdy_o      = (count_q != Q_FULL);
    assign q_count_o      = count_q;
    assign infl_o         = infl_q;
    assign bpu_req_o      = bpu_req_q;
    assign bpu_addr_o     = bpu_addr_q;
    assign bpu_update_o   = bpu_update_q;
    assign bpu_pc_o       = bpu_pc_q;
    assign bpu_taken_o    = bpu_taken_q;
    assign bpu_tage_ind_o = bpu_tage_ind_q;
    assign bpu_flush_o    = bpu_flush_q;

endmodule

// File: tb/tb_bpu_sched.sv
// Directed self-checking bench for bpu_sched with hand-computed expectations.
module tb_bpu_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req_i = 1'b0;
    logic [31:0] fetch_addr_i = 32'h0;
    logic        fetch_gnt_o;
    logic        ret_val_i = 1'b0;
    logic        ret_rdy_o;
    logic [31:0] ret_pc_i = 32'h0;
    logic        ret_taken_i = 1'b0;
    logic [3:0]  ret_tage_ind_i = 4'h0;
    logic        ret_mispred_i = 1'b0;
    logic        bpu_req_o;
    logic [31:0] bpu_addr_o;
    logic        bpu_update_o;
    logic [31:0] bpu_pc_o;
    logic        bpu_taken_o;
    logic [3:0]  bpu_tage_ind_o;
    logic        bpu_flush_o;
    logic [3:0]  q_count_o;
    logic [3:0]  infl_o;

    int n_pass  = 0;
    int n_total = 0;

    bpu_sched dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
        .ret_val_i(ret_val_i), .ret_rdy_o(ret_rdy_o), .ret_pc_i(ret_pc_i),
        .ret_taken_i(ret_taken_i), .ret_tage_ind_i(ret_tage_ind_i), .ret_mispred_i(ret_mispred_i),
        .bpu_req_o(bpu_req_o), .bpu_addr_o(bpu_addr_o), .bpu_update_o(bpu_update_o),
        .bpu_pc_o(bpu_pc_o), .bpu_taken_o(bpu_taken_o), .bpu_tage_ind_o(bpu_tage_ind_o),
        .bpu_flush_o(bpu_flush_o), .q_count_o(q_count_o), .infl_o(infl_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic ret(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [3:0] ind, input logic mp);
        ret_val_i      = v;
        ret_pc_i       = pc;
        ret_taken_i    = tk;
        ret_tage_ind_i = ind;
        ret_mispred_i  = mp;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, fetch_gnt_o, 0);
        chk({tag, "_req"}, bpu_req_o, 0);
        chk({tag, "_addr"}, bpu_addr_o, 0);
        chk({tag, "_upd"}, bpu_update_o, 0);
        chk({tag, "_pc"}, bpu_pc_o, 0);
        chk({tag, "_taken"}, bpu_taken_o, 0);
        chk({tag, "_ind"}, bpu_tage_ind_o, 0);
        chk({tag, "_flush"}, bpu_flush_o, 0);
        chk({tag, "_rdy"}, ret_rdy_o, 1);
        chk({tag, "_qcnt"}, q_count_o, 0);
        chk({tag, "_infl"}, infl_o, 0);
    endtask

    // Holds reset across one clock edge with fetch requesting; returns in cycle 0 after release
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        fetch_req_i = 1'b1;
        ret(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        #1;
        chk_idle(tag);
        next();
        rst_n = 1'b1;
        fetch_req_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        #1;

        // Fetch only: 15 grants then blocked by the in-flight limit
        do_reset("rst0");
        for (int i = 0; i < 20; i++) begin
            fetch_req_i  = 1'b1;
            fetch_addr_i = 32'h1000 + 32'(i * 4);
            #1;
            chk("t1_gnt", fetch_gnt_o, (i < 15) ? 1 : 0);
            chk("t1_req", bpu_req_o, (i >= 1 && i <= 15) ? 1 : 0);
            if (i >= 1 && i <= 15) chk("t1_addr", bpu_addr_o, 32'h1000 + 32'((i - 1) * 4));
            next();
        end
        chk("t1_infl", infl_o, 15);

        // Starvation: four fetch grants, then the queued update is forced through
        do_reset("rst1");
        for (int i = 0; i < 5; i++) begin
            fetch_req_i = 1'b1;
            next();
        end
        fetch_req_i = 1'b0;
        ret(1'b1, 32'hA5A0, 1'b1, 4'h9, 1'b0);
        #1;
        chk("t2_nogntc5", fetch_gnt_o, 0);
        next();
        ret(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        fetch_req_i = 1'b1;
        #1;
        chk("t2_infl5", infl_o, 5);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_gnt", fetch_gnt_o, 1);
            next();
        end
        #1;
        chk("t2_gnt_c10", fetch_gnt_o, 0);
        chk("t2_qcnt_c10", q_count_o, 1);
        next();
        #1;
        chk("t2_upd", bpu_update_o, 1);
        chk("t2_pc", bpu_pc_o, 32'hA5A0);
        chk("t2_taken", bpu_taken_o, 1);
        chk("t2_ind", bpu_tage_ind_o, 4'h9);
        chk("t2_req_c11", bpu_req_o, 0);
        chk("t2_gnt_c11", fetch_gnt_o, 1);
        chk("t2_infl8", infl_o, 8);
        chk("t2_qcnt0", q_count_o, 0);
        next();
        #1;
        chk("t2_req_c12", bpu_req_o, 1);
        chk("t2_upd_c12", bpu_update_o, 0);

        // Full queue: update takes priority, enqueue refused while full
        do_reset("rst2");
        for (int i = 0; i < 8; i++) begin
            ret(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 4'(i), 1'b0);
            #1;
            chk("t3_rdy_fill", ret_rdy_o, 1);
            next();
        end
        ret(1'b1, 32'h3F00, 1'b0, 4'h0, 1'b0);
        fetch_req_i = 1'b1;
        #1;
        chk("t3_rdy_c8", ret_rdy_o, 0);
        chk("t3_qcnt_c8", q_count_o, 8);
        chk("t3_gnt_c8", fetch_gnt_o, 1);
        next();
        #1;
        chk("t3_gnt_c9", fetch_gnt_o, 0);
        chk("t3_rdy_c9", ret_rdy_o, 0);
        chk("t3_qcnt_c9", q_count_o, 8);
        chk("t3_infl_c9", infl_o, 1);
        chk("t3_req_c9", bpu_req_o, 1);
        next();
        ret(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        #1;
        chk("t3_rdy_c10", ret_rdy_o, 1);
        chk("t3_qcnt_c10", q_count_o, 7);
        chk("t3_upd_c10", bpu_update_o, 1);
        chk("t3_pc_c10", bpu_pc_o, 32'h3000);
        chk("t3_infl_c10", infl_o, 0);
        chk("t3_gnt_c10", fetch_gnt_o, 1);
        chk("t3_req_c10", bpu_req_o, 0);
        next();

        // Mispredict: flush with the update, remaining entry still drains
        do_reset("rst3");
        for (int i = 0; i < 4; i++) begin
            fetch_req_i = 1'b1;
            next();
        end
        ret(1'b1, 32'hA000, 1'b1, 4'h5, 1'b1);
        next();
        ret(1'b1, 32'hB000, 1'b0, 4'h3, 1'b0);
        #1;
        chk("t4_gnt_c5", fetch_gnt_o, 1);
        next();
        ret(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        fetch_req_i = 1'b0;
        #1;
        chk("t4_qcnt_c6", q_count_o, 2);
        chk("t4_infl_c6", infl_o, 6);
        next();
        fetch_req_i = 1'b1;
        #1;
        chk("t4_upd_a", bpu_update_o, 1);
        chk("t4_flush_a", bpu_flush_o, 1);
        chk("t4_pc_a", bpu_pc_o, 32'hA000);
        chk("t4_taken_a", bpu_taken_o, 1);
        chk("t4_ind_a", bpu_tage_ind_o, 4'h5);
        chk("t4_infl_a", infl_o, 1);
        chk("t4_gnt_c7", fetch_gnt_o, 0);
        chk("t4_req_c7", bpu_req_o, 0);
        next();
        #1;
        chk("t4_upd_b", bpu_update_o, 1);
        chk("t4_flush_b", bpu_flush_o, 0);
        chk("t4_pc_b", bpu_pc_o, 32'hB000);
        chk("t4_taken_b", bpu_taken_o, 0);
        chk("t4_ind_b", bpu_tage_ind_o, 4'h3);
        chk("t4_infl_b", infl_o, 0);
        chk("t4_gnt_c8", fetch_gnt_o, 0);
        next();
        #1;
        chk("t4_gnt_c9", fetch_gnt_o, 0);
        next();
        #1;
        chk("t4_gnt_c10", fetch_gnt_o, 0);
        chk("t4_upd_c10", bpu_update_o, 0);
        next();
        #1;
        chk("t4_gnt_c11", fetch_gnt_o, 1);
        next();
        #1;
        chk("t4_req_c12", bpu_req_o, 1);

        // Back-to-back mispredicts: second one restarts the flush window
        do_reset("rst4");
        for (int i = 0; i < 4; i++) begin
            fetch_req_i = 1'b1;
            next();
        end
        ret(1'b1, 32'hC000, 1'b0, 4'h1, 1'b1);
        next();
        ret(1'b1, 32'hD000, 1'b1, 4'h2, 1'b1);
        next();
        ret(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        fetch_req_i = 1'b0;
        #1;
        chk("t5_gnt_c6", fetch_gnt_o, 0);
        next();
        fetch_req_i = 1'b1;
        #1;
        chk("t5_flush_1", bpu_flush_o, 1);
        chk("t5_pc_1", bpu_pc_o, 32'hC000);
        chk("t5_infl_1", infl_o, 1);
        chk("t5_gnt_c7", fetch_gnt_o, 0);
        next();
        #1;
        chk("t5_upd_2", bpu_update_o, 1);
        chk("t5_flush_2", bpu_flush_o, 1);
        chk("t5_pc_2", bpu_pc_o, 32'hD000);
        chk("t5_infl_2", infl_o, 0);
        for (int i = 8; i < 12; i++) begin
            #1;
            chk("t5_gnt_blocked", fetch_gnt_o, 0);
            next();
        end
        #1;
        chk("t5_gnt_c12", fetch_gnt_o, 1);
        next();

        // Reset mid-operation with entries queued and the flush window open
        do_reset("rst5");
        for (int i = 0; i < 3; i++) begin
            fetch_req_i = 1'b1;
            next();
        end
        ret(1'b1, 32'hE000, 1'b1, 4'h7, 1'b1);
        next();
        ret(1'b1, 32'hE100, 1'b0, 4'h1, 1'b0);
        next();
        ret(1'b1, 32'hE200, 1'b1, 4'h2, 1'b0);
        next();
        fetch_req_i = 1'b0;
        ret(1'b1, 32'hE300, 1'b0, 4'h3, 1'b0);
        next();
        ret(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        fetch_req_i = 1'b1;
        #1;
        chk("t6_upd_pre", bpu_update_o, 1);
        chk("t6_flush_pre", bpu_flush_o, 1);
        chk("t6_qcnt_pre", q_count_o, 3);
        chk("t6_infl_pre", infl_o, 2);
        chk("t6_gnt_pre", fetch_gnt_o, 0);
        rst_n = 1'b0;
        #1;
        chk_idle("t6_async");
        next();
        rst_n = 1'b1;
        #1;
        chk("t6_gnt_rel", fetch_gnt_o, 1);
        chk("t6_qcnt_rel", q_count_o, 0);
        chk("t6_rdy_rel", ret_rdy_o, 1);
        next();
        #1;
        chk("t6_req_post", bpu_req_o, 1);
        chk("t6_infl_post", infl_o, 1);
        chk("t6_upd_post", bpu_update_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
